// File: rtl/lcd_text_writer_if.sv
// Character-stream input and display-RAM write port of lcd_text_writer.
interface lcd_text_writer_if #(parameter int ADDR_W = 6);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [8:0]        mem_data;
  logic              mem_we;
  logic              refresh;
  logic              busy;

  modport master (output in_data, in_valid,
                  input  in_ready, mem_addr, mem_data, mem_we, refresh, busy);
  modport slave  (input  in_data, in_valid,
                  output in_ready, mem_addr, mem_data, mem_we, refresh, busy);
endinterface

// File: rtl/lcd_text_writer.sv
// Writes a character stream into LCD display RAM with cursor and control-char handling.
// Define LCD_CURSOR_WRAP_EN to wrap a full line onto the other line instead of dropping chars.
module lcd_text_writer #(
  parameter int LINE1    = 5,
  parameter int LINE_LEN = 16,
  parameter int ADDR_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  lcd_text_writer_if.slave   bus
);
  typedef enum logic [1:0] {CLR, IDLE, WR, DONE} state_t;

  localparam logic [ADDR_W-1:0] BASE0    = ADDR_W'(LINE1);
  localparam logic [ADDR_W-1:0] BASE1    = ADDR_W'(LINE1 + LINE_LEN + 1);
  localparam logic [ADDR_W-1:0] CH_LINE  = ADDR_W'(LINE1 + LINE_LEN);
  localparam logic [ADDR_W-1:0] LEN      = ADDR_W'(LINE_LEN);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(2 * LINE_LEN);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
  localparam logic [8:0]        BLANK    = 9'h120;
  localparam logic [8:0]        LINE_CMD = 9'h0C0;

  state_t            state, state_n;
  logic [ADDR_W-1:0] clr_idx, clr_idx_n, col, col_n;
  logic              line, line_n;
  logic [7:0]        ch, cur_byte;
  logic [ADDR_W-1:0] addr_q, wr_addr;
  logic [8:0]        data_q, wr_data;
  logic              wr_en, ready, ref_p, bsy;

  logic              dec_wr, dec_ff, dec_line, tgt_line;
  logic [ADDR_W-1:0] dec_col, tgt_col, dec_addr;
  logic [8:0]        dec_data;

  // Same decoder serves the handshake (live byte) and WR (latched byte); the
  // cursor has not moved in between, so both see identical results.
  always_comb begin
    cur_byte = (state == IDLE) ? bus.in_data : ch;
    dec_wr   = 1'b0;
    dec_ff   = 1'b0;
    dec_line = line;
    dec_col  = col;
    tgt_line = line;
    tgt_col  = col;
    dec_data = {1'b1, cur_byte};
    if (cur_byte >= 8'h20 && cur_byte <= 8'h7E) begin
      if (col < LEN) begin
        dec_wr  = 1'b1;
        dec_col = col + ONE;
      end
`ifdef LCD_CURSOR_WRAP_EN
      else begin
        dec_wr   = 1'b1;
        tgt_line = ~line;
        tgt_col  = '0;
        dec_line = ~line;
        dec_col  = ONE;
      end
`endif
    end else begin
      case (cur_byte)
        8'h08: if (col != '0) begin
          dec_wr   = 1'b1;
          tgt_col  = col - ONE;
          dec_col  = col - ONE;
          dec_data = BLANK;
        end
        8'h0A: begin dec_line = 1'b1; dec_col = '0; end
        8'h0D: dec_col = '0;
        8'h0C: dec_ff = 1'b1;
        default: ;
      endcase
    end
    dec_addr = (tgt_line ? BASE1 : BASE0) + tgt_col;
  end

  always_comb begin
    state_n   = state;
    clr_idx_n = clr_idx;
    col_n     = col;
    line_n    = line;
    wr_en     = 1'b0;
    wr_addr   = addr_q;
    wr_data   = data_q;
    ready     = 1'b0;
    ref_p     = 1'b0;
    bsy       = 1'b0;
    unique case (state)
      CLR: begin
        wr_en     = 1'b1;
        bsy       = 1'b1;
        wr_addr   = BASE0 + clr_idx;
        wr_data   = (wr_addr == CH_LINE) ? LINE_CMD : BLANK;
        clr_idx_n = clr_idx + ONE;
        if (clr_idx == CLR_LAST) state_n = DONE;
      end
      IDLE: begin
        ready = 1'b1;
        if (bus.in_valid) begin
          if (dec_ff) begin
            col_n     = '0;
            line_n    = 1'b0;
            clr_idx_n = '0;
            state_n   = CLR;
          end else if (dec_wr) begin
            state_n = WR;
          end else begin
            col_n   = dec_col;
            line_n  = dec_line;
            state_n = DONE;
          end
        end
      end
      WR: begin
        wr_en   = 1'b1;
        bsy     = 1'b1;
        wr_addr = dec_addr;
        wr_data = dec_data;
        col_n   = dec_col;
        line_n  = dec_line;
        state_n = DONE;
      end
      DONE: begin
        ref_p   = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

  // Outputs are forced low while rst is held so an aborted clear stops at once.
  assign bus.mem_we   = rst & wr_en;
  assign bus.in_ready = rst & ready;
  assign bus.refresh  = rst & ref_p;
  assign bus.busy     = rst & bsy;
  assign bus.mem_addr = rst ? wr_addr : '0;
  assign bus.mem_data = rst ? wr_data : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= CLR;
      clr_idx <= '0;
      col     <= '0;
      line    <= 1'b0;
      ch      <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state   <= state_n;
      clr_idx <= clr_idx_n;
      col     <= col_n;
      line    <= line_n;
      if (state == IDLE && bus.in_valid) ch <= bus.in_data;
      if (wr_en) begin
        addr_q <= wr_addr;
        data_q <= wr_data;
      end
    end
  end
endmodule

// File: tb/tb_lcd_text_writer.sv
// Scoreboard bench for lcd_text_writer: directed bytes push expected writes/refreshes, a monitor compares.
module tb_lcd_text_writer;
  localparam int LINE1 = 5, LINE_LEN = 16, ADDR_W = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lcd_text_writer_if #(.ADDR_W(ADDR_W)) bus ();
  lcd_text_writer #(.LINE1(LINE1), .LINE_LEN(LINE_LEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    bit         is_ref;
    logic [5:0] addr;
    logic [8:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got event required none", name);
  endtask

  task automatic push_wr(input int addr, input logic [8:0] data);
    ev_t e;
    e.is_ref = 1'b0;
    e.addr   = 6'(addr);
    e.data   = data;
    exp_q.push_back(e);
  endtask

  task automatic push_ref();
    ev_t e;
    e.is_ref = 1'b1;
    e.addr   = '0;
    e.data   = '0;
    exp_q.push_back(e);
  endtask

  task automatic push_clear(input int n);
    for (int i = 0; i < n; i++) push_wr(5 + i, (i == 16) ? 9'h0C0 : 9'h120);
  endtask

  // Monitor: samples mid-cycle, pops one expected event per observed write/refresh.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (bus.mem_we) begin
        if (exp_q.size() == 0) flag("unexpected_write");
        else begin
          e = exp_q.pop_front();
          check("write_kind", 32'(bus.mem_we & ~e.is_ref), 32'(1));
          check("write_addr", 32'(bus.mem_addr), 32'(e.addr));
          check("write_data", 32'(bus.mem_data), 32'(e.data));
        end
      end
      if (bus.refresh) begin
        if (exp_q.size() == 0) flag("unexpected_refresh");
        else begin
          e = exp_q.pop_front();
          check("refresh_kind", 32'(e.is_ref), 32'(1));
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, output time hs);
    int  n;
    bit  rdy;
    n = 0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    forever begin
      rdy = bus.in_ready;
      @(posedge clk);
      if (rdy) break;
      n++;
      if (n > 100) begin
        flag("handshake_timeout");
        break;
      end
      #1;
    end
    hs = $time;
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic pr(input logic [7:0] b, input int addr);
    time t;
    push_wr(addr, {1'b1, b});
    push_ref();
    send(b, t);
  endtask

  task automatic ctl(input logic [7:0] b);
    time t;
    push_ref();
    send(b, t);
  endtask

  task automatic bs(input int addr);
    time t;
    push_wr(addr, 9'h120);
    push_ref();
    send(8'h08, t);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    time t1, t2;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_mem_we",   32'(bus.mem_we),   32'(0));
    check("rst_in_ready", 32'(bus.in_ready), 32'(0));
    check("rst_refresh",  32'(bus.refresh),  32'(0));
    check("rst_busy",     32'(bus.busy),     32'(0));
    check("rst_mem_addr", 32'(bus.mem_addr), 32'(0));
    check("rst_mem_data", 32'(bus.mem_data), 32'(0));

    // Power-up clear: first write in the very first cycle after release.
    push_clear(33);
    push_ref();
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("clr_first_we",   32'(bus.mem_we),   32'(1));
    check("clr_first_addr", 32'(bus.mem_addr), 32'(5));
    check("clr_busy",       32'(bus.busy),     32'(1));
    drain();

    // 'A' then 'B' back-to-back: write one cycle after handshake, next accept 3 cycles later.
    push_wr(5, 9'h141);
    push_ref();
    send(8'h41, t1);
    check("lat_we",    32'(bus.mem_we),   32'(1));
    check("lat_addr",  32'(bus.mem_addr), 32'(5));
    check("lat_ready", 32'(bus.in_ready), 32'(0));
    push_wr(6, 9'h142);
    push_ref();
    send(8'h42, t2);
    check("throughput_cycles", 32'((t2 - t1) / 10), 32'(3));
    drain();
    check("hold_addr", 32'(bus.mem_addr), 32'(6));
    check("hold_data", 32'(bus.mem_data), 32'(9'h142));

    // Newline then 'Z' lands on line 1, col 0.
    ctl(8'h0A);
    pr(8'h5A, 22);
    drain();

    // Form feed: full clear, cursor home.
    push_clear(33);
    push_ref();
    send(8'h0C, t1);
    drain();

    // Backspace overwrites and the next char reuses that cell.
    pr(8'h48, 5);
    pr(8'h49, 6);
    bs(6);
    pr(8'h4A, 6);
    ctl(8'h0D);
    ctl(8'h08);
    ctl(8'h01);
    ctl(8'h7F);
    drain();

    // Fill line 0; the 17th char is dropped or wraps to line 1.
    for (int i = 0; i < 16; i++) pr(8'(8'h30 + i), 5 + i);
`ifdef LCD_CURSOR_WRAP_EN
    pr(8'h58, 22);
    bs(22);
`else
    ctl(8'h58);
    bs(20);
`endif
    ctl(8'h0A);
    pr(8'h4B, 22);
    pr(8'h7E, 23);
    drain();

    // Reset in the middle of a clear: writes 0..9 happen, the one at index 10 never does.
    push_clear(10);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_we_now",  32'(bus.mem_we), 32'(0));
    check("abort_busy",    32'(bus.busy),   32'(0));
    @(posedge clk);
    #1;
    check("abort_we_next", 32'(bus.mem_we), 32'(0));
    drain();
    push_clear(33);
    push_ref();
    @(posedge clk);
    #1 rst = 1'b1;
    drain();
    pr(8'h51, 5);
    push_clear(33);
    push_ref();
    send(8'h0C, t1);
    pr(8'h52, 5);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/lcd_text_writer.md
Name: lcd_text_writer

Overview:
- Writer side of the LCD display memory. It accepts a byte stream of characters over a valid/ready handshake and writes 9-bit {RS, data} words into the display RAM.
- The LCD sequencer reads that RAM: addresses 0..4 are its hard-coded init commands; from address LINE1 up it reads line-1 chars, the line-change command, then line-2 chars.
- This block owns addresses LINE1..LINE1+32. It maintains a cursor and interprets a small set of control characters.

Parameters:
- LINE1, 5, base address of line-1 character 0
- LINE_LEN, 16, characters per line
- ADDR_W, 6, display RAM address width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- in_data  in  8  character byte
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept a byte this cycle
- mem_addr  out  ADDR_W  display RAM write address
- mem_data  out  9  write word: [8]=RS, [7:0]=char/command
- mem_we  out  1  write strobe, one word per cycle
- refresh  out  1  one-cycle pulse when a character or clear operation completes
- busy  out  1  high in CLR and WR states

Behaviour:
- Address map:
  - line0 col c -> LINE1+c
  - CH_LINE = LINE1+LINE_LEN holds 9'h0C0 (set DDRAM addr 0x40)
  - line1 col c -> LINE1+LINE_LEN+1+c
- Blank cell = 9'h120 (RS=1, space).
- Reset (rst=0): state<=CLR, clr_idx<=0, cursor line=0 col=0; all outputs 0. Reset asserted mid-operation aborts it immediately, no further writes.
- States: CLR, IDLE, WR, DONE.
- CLR:
  - One write per cycle, clr_idx 0..2*LINE_LEN (33 writes).
  - mem_addr=LINE1+clr_idx; mem_data=9'h0C0 when the address is CH_LINE, else 9'h120; mem_we=1; in_ready=0.
  - After the last write -> DONE. The first write occurs in the first cycle after rst rises.
- IDLE:
  - in_ready=1. Handshake when in_valid && in_ready; in_data is latched on that cycle.
  - The byte is decoded at the handshake:
    - 0x20..0x7E printable: if col<LINE_LEN -> WR writes {1'b1,char} at the cursor, then col++. If col==LINE_LEN, handling depends on LCD_CURSOR_WRAP_EN.
    - 0x08 backspace: if col>0, col-- and WR writes 9'h120 at the new position; if col==0, no write -> DONE.
    - 0x0A newline: line=1, col=0, no write -> DONE. Also applies when already on line1.
    - 0x0D carriage return: col=0, no write -> DONE.
    - 0x0C form feed: cursor to (0,0), clr_idx=0 -> CLR.
    - Any other byte: accepted and dropped -> DONE.
- WR: exactly one cycle with mem_we=1; in_ready=0; -> DONE.
- DONE: refresh=1 for one cycle; mem_we=0; in_ready=0; -> IDLE.
- Latency for a printable byte:
  - handshake at cycle N
  - mem_we at N+1
  - refresh at N+2
  - in_ready=1 again at N+3
  - Maximum throughput is one byte per 3 cycles.
- Column counter is ADDR_W bits wide, range 0..LINE_LEN; it never exceeds LINE_LEN. The cursor updates in the same edge as the write.
- mem_we is never asserted in IDLE or DONE. mem_addr and mem_data hold their last value when mem_we=0.

Optional Feature:
- Macro LCD_CURSOR_WRAP_EN.
- Defined: a printable byte at col==LINE_LEN wraps the cursor to col 0 of the other line (line0->line1, line1->line0). The char is written at that col 0 and col becomes 1, with the same latency.
- Undefined: a printable byte at col==LINE_LEN is accepted and dropped. No write occurs, refresh still pulses, and the cursor is unchanged.

Test Plan:
- Release rst -> 33 consecutive mem_we cycles at addresses 5..37. Addr 21 gets 9'h0C0, all others 9'h120. Then one refresh pulse, then in_ready=1.
- Send 'A'(0x41) at cursor (0,0) -> mem_we with addr 5, data 9'h141 one cycle after handshake; refresh the next cycle; the next byte is accepted 3 cycles after the first.
- Send 0x0A then 'Z'(0x5A) -> no write for 0x0A. 'Z' is written at addr 22 with data 9'h15A.
- Send 'H','I' then 0x08 -> writes at addrs 5 and 6, then 9'h120 to addr 6; the next char lands at addr 6.
- Send 17 printable chars on line0 -> with the macro undefined, the 17th produces no write. With LCD_CURSOR_WRAP_EN defined, it is written to addr 22.
- Assert rst during CLR at clr_idx=10 -> mem_we=0 next cycle. After release, CLR restarts at addr 5 and 0x0C form feed behaves identically (33 writes).
